// File: rtl/gpu_bus_bridge.sv
// Wishbone classic slave bridging the CPU bus to GPU memory-mapped targets.
// Decodes an address field into regions, adds wait states, issues one-cycle strobes.
module gpu_bus_bridge #(
  parameter int NUM_REGIONS   = 4,
  parameter int ADDR_W        = 27,
  parameter int REGION_SEL_LO = 12,
  parameter int REGION_SEL_W  = 4,
  parameter int WAIT_STATES   = 1,
  parameter int RD_LATENCY    = 1
) (
  input  logic                      clk_100MHz,
  input  logic                      wb_rst_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [3:0]                wb_sel_i,
  input  logic [ADDR_W-1:0]         wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic [NUM_REGIONS-1:0]    o_reg_we,
  output logic [NUM_REGIONS-1:0]    o_reg_re,
  output logic [ADDR_W-1:0]         o_reg_addr,
  output logic [31:0]               o_reg_wdata,
  output logic [3:0]                o_reg_sel,
  input  logic [NUM_REGIONS*32-1:0] i_reg_rdata
);

  // state    | meaning
  // S_IDLE   | waiting for cyc & stb; latches the request
  // S_WAIT   | counting wait states before the strobe
  // S_ACCESS | one-cycle we/re strobe to the selected region
  // S_RDWAIT | waiting for target read data
  // S_ACK    | one-cycle normal termination
  // S_ERR    | one-cycle error termination (unmapped region)
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RDWAIT,
    S_ACK,
    S_ERR
  } state_t;

  localparam int SEL_CMP_W = REGION_SEL_W + 1;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_W-1:0]       adr_q, adr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             dat_q, dat_d;
  logic [3:0]              sel_q, sel_d;
  logic                    we_q, we_d;
  logic [REGION_SEL_W-1:0] region_q, region_d;

  logic [REGION_SEL_W-1:0] region_in;
  logic                    mapped_in;
  logic [NUM_REGIONS-1:0]  onehot;
  logic [31:0]             rdata_sel;

  assign region_in = wb_adr_i[REGION_SEL_LO +: REGION_SEL_W];
  assign mapped_in = {1'b0, region_in} < SEL_CMP_W'(NUM_REGIONS);

  always_comb begin
    onehot    = '0;
    rdata_sel = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (region_q == REGION_SEL_W'(k)) begin
        onehot[k] = 1'b1;
        rdata_sel = i_reg_rdata[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    region_d = region_q;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d    = wb_adr_i;
          wdata_d  = wb_dat_i;
          sel_d    = wb_sel_i;
          we_d     = wb_we_i;
          region_d = region_in;
          if (!mapped_in) begin
            state_d = S_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        // An abort here still lets this cycle's strobe go out; only the ack is dropped.
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (we_q) begin
          state_d = S_ACK;
        end else if (RD_LATENCY == 0) begin
          state_d = S_ACK;
          dat_d   = rdata_sel;
        end else begin
          state_d = S_RDWAIT;
          cnt_d   = 4'(RD_LATENCY - 1);
        end
      end
      S_RDWAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          dat_d   = rdata_sel;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      wdata_q  <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      region_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      region_q <= region_d;
    end
  end

  assign o_reg_we    = ((state_q == S_ACCESS) && we_q)  ? onehot : '0;
  assign o_reg_re    = ((state_q == S_ACCESS) && !we_q) ? onehot : '0;
  assign wb_ack_o    = (state_q == S_ACK);
  assign wb_err_o    = (state_q == S_ERR);
  assign wb_dat_o    = dat_q;
  assign o_reg_addr  = adr_q;
  assign o_reg_wdata = wdata_q;
  assign o_reg_sel   = sel_q;

endmodule

// File: tb/tb_gpu_bus_bridge.sv
// Bench for gpu_bus_bridge: two instances (defaults, and 3 wait states / zero read latency)
// checked cycle by cycle against a transaction-timeline model.
module tb_gpu_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       [2];
  logic         cyc       [2];
  logic         stb       [2];
  logic         we        [2];
  logic [3:0]   sel       [2];
  logic [26:0]  adr       [2];
  logic [31:0]  wdat      [2];
  logic [31:0]  rdat_o    [2];
  logic         ack       [2];
  logic         err       [2];
  logic [3:0]   reg_we    [2];
  logic [3:0]   reg_re    [2];
  logic [26:0]  reg_addr  [2];
  logic [31:0]  reg_wdata [2];
  logic [3:0]   reg_sel   [2];
  logic [127:0] reg_rdata [2];

  gpu_bus_bridge dut0 (
    .clk_100MHz(clk), .wb_rst_i(rst[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]),
    .wb_dat_o(rdat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
    .o_reg_we(reg_we[0]), .o_reg_re(reg_re[0]), .o_reg_addr(reg_addr[0]),
    .o_reg_wdata(reg_wdata[0]), .o_reg_sel(reg_sel[0]), .i_reg_rdata(reg_rdata[0])
  );

  gpu_bus_bridge #(.WAIT_STATES(3), .RD_LATENCY(0)) dut1 (
    .clk_100MHz(clk), .wb_rst_i(rst[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]),
    .wb_dat_o(rdat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
    .o_reg_we(reg_we[1]), .o_reg_re(reg_re[1]), .o_reg_addr(reg_addr[1]),
    .o_reg_wdata(reg_wdata[1]), .o_reg_sel(reg_sel[1]), .i_reg_rdata(reg_rdata[1])
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] dat_model [2];

  typedef struct {
    int          d;
    bit          w;
    logic [26:0] a;
    logic [31:0] wd;
    logic [3:0]  s;
    logic [31:0] rd;
    int          drop;
    bit          chain;
    int          e_stb_c;
    logic [3:0]  e_stb_v;
    int          e_ack_c;
    int          e_err_c;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int d, input int c,
                     input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0d: got %h expected %h", name, d, c, act, exp);
    end
  endtask

  // Region r gets the valid word only once valid is set; before that it carries the complement.
  task automatic drive_rdata(input int d, input int r, input bit valid, input logic [31:0] v);
    for (int k = 0; k < 4; k++)
      reg_rdata[d][32*k +: 32] = (k == r) ? (valid ? v : ~v) : $urandom;
  endtask

  // One transfer: request presented in cycle 0, outputs checked at each following negedge.
  task automatic run_txn(input int d, input bit w, input logic [26:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input logic [31:0] rd, input int drop,
                         input bit chain, output int o_stb_c, output logic [3:0] o_stb_v,
                         output int o_ack_c, output int o_err_c);
    int          wst, lat, r, stb_c, ack_c, err_c, term_c, last_c, valid_c;
    bit          mapped, aborted, capture, chain_eff;
    logic [3:0]  hot, exp_we, exp_re;
    logic [31:0] exp_dat;
    wst       = (d == 0) ? 1 : 3;
    lat       = (d == 0) ? 1 : 0;
    r         = int'(a[15:12]);
    mapped    = (r < 4);
    hot       = mapped ? 4'(1 << r) : 4'd0;
    stb_c     = mapped ? wst + 1 : -1;
    ack_c     = mapped ? (w ? wst + 2 : wst + 2 + lat) : -1;
    err_c     = mapped ? -1 : 1;
    aborted   = mapped && (drop > 0) && (drop < ack_c);
    if (aborted && drop <= wst) stb_c = -1;
    if (aborted) ack_c = -1;
    capture   = mapped && !w && !aborted;
    chain_eff = chain && mapped && !aborted;
    term_c    = aborted ? drop : (mapped ? ack_c : err_c);
    valid_c   = wst + 1 + lat;
    last_c    = chain_eff ? ack_c : wst + lat + 4;
    o_stb_c = -1; o_stb_v = 4'd0; o_ack_c = -1; o_err_c = -1;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd; sel[d] = s;
    drive_rdata(d, r, 1'b0, rd);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      exp_we  = (c == stb_c && w)  ? hot : 4'd0;
      exp_re  = (c == stb_c && !w) ? hot : 4'd0;
      exp_dat = (capture && c >= ack_c) ? rd : dat_model[d];
      chk("we_strobe", d, c, reg_we[d], exp_we);
      chk("re_strobe", d, c, reg_re[d], exp_re);
      chk("ack_err", d, c, {ack[d], err[d]}, {c == ack_c, c == err_c});
      chk("rd_data", d, c, rdat_o[d], exp_dat);
      chk("latched", d, c, {1'b0, reg_addr[d], reg_wdata[d], reg_sel[d]}, {1'b0, a, wd, s});
      if (o_stb_c < 0 && (reg_we[d] | reg_re[d]) != 4'd0) begin
        o_stb_c = c;
        o_stb_v = reg_we[d] | reg_re[d];
      end
      if (ack[d] && o_ack_c < 0) o_ack_c = c;
      if (err[d] && o_err_c < 0) o_err_c = c;
      if (c >= term_c && !chain_eff) begin
        cyc[d] = 1'b0;
        stb[d] = 1'b0;
      end
      drive_rdata(d, r, c >= valid_c, rd);
    end
    if (capture) dat_model[d] = rd;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          os, oa, oe, d, r, drop;
    logic [3:0]  ov;
    bit          w, chain;
    logic [26:0] a;
    logic [31:0] v;

    tbl[0]  = '{0, 1'b1, 27'h42123, 32'hDEADBEEF, 4'hF, 32'h0,        0, 1'b0,  2, 4'b0100,  3, -1, 32'h0};
    tbl[1]  = '{0, 1'b0, 27'h41123, 32'h0,        4'hF, 32'h12345678, 0, 1'b0,  2, 4'b0010,  4, -1, 32'h12345678};
    tbl[2]  = '{0, 1'b0, 27'h45123, 32'h0,        4'hF, 32'h0,        0, 1'b0, -1, 4'b0000, -1,  1, 32'h12345678};
    tbl[3]  = '{0, 1'b1, 27'h40123, 32'h0F0F0F0F, 4'h0, 32'h0,        0, 1'b0,  2, 4'b0001,  3, -1, 32'h12345678};
    tbl[4]  = '{0, 1'b1, 27'h43123, 32'h11111111, 4'hF, 32'h0,        1, 1'b0, -1, 4'b0000, -1, -1, 32'h12345678};
    tbl[5]  = '{0, 1'b1, 27'h43123, 32'hA5A5A5A5, 4'hF, 32'h0,        0, 1'b0,  2, 4'b1000,  3, -1, 32'h12345678};
    tbl[6]  = '{0, 1'b0, 27'h43123, 32'h0,        4'hF, 32'hCAFEF00D, 0, 1'b1,  2, 4'b1000,  4, -1, 32'hCAFEF00D};
    tbl[7]  = '{0, 1'b0, 27'h40123, 32'h0,        4'hF, 32'h0BADF00D, 0, 1'b0,  2, 4'b0001,  4, -1, 32'h0BADF00D};
    tbl[8]  = '{0, 1'b0, 27'h42123, 32'h0,        4'hF, 32'h77777777, 3, 1'b0,  2, 4'b0100, -1, -1, 32'h0BADF00D};
    tbl[9]  = '{0, 1'b0, 27'h41123, 32'h0,        4'hF, 32'h88888888, 2, 1'b0,  2, 4'b0010, -1, -1, 32'h0BADF00D};
    tbl[10] = '{1, 1'b1, 27'h41123, 32'h55AA55AA, 4'h3, 32'h0,        0, 1'b0,  4, 4'b0010,  5, -1, 32'h0};
    tbl[11] = '{1, 1'b0, 27'h42123, 32'h0,        4'hF, 32'h11223344, 0, 1'b0,  4, 4'b0100,  5, -1, 32'h11223344};
    tbl[12] = '{1, 1'b0, 27'h4F123, 32'h0,        4'hF, 32'h0,        0, 1'b0, -1, 4'b0000, -1,  1, 32'h11223344};
    tbl[13] = '{1, 1'b1, 27'h40123, 32'h99999999, 4'hF, 32'h0,        2, 1'b0, -1, 4'b0000, -1, -1, 32'h11223344};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; sel[i] = 4'd0;
      adr[i] = '0; wdat[i] = '0; reg_rdata[i] = '0; dat_model[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_state_a", i, 0, {rdat_o[i], reg_wdata[i]}, 64'd0);
      chk("reset_state_b", i, 0, {reg_we[i], reg_re[i], ack[i], err[i], reg_sel[i], reg_addr[i]}, 64'd0);
      rst[i] = 1'b0;
    end

    for (int i = 0; i < 14; i++) begin
      run_txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].s, tbl[i].rd, tbl[i].drop,
              tbl[i].chain, os, ov, oa, oe);
      chk("tbl_stb_cycle", tbl[i].d, i, os, tbl[i].e_stb_c);
      chk("tbl_stb_value", tbl[i].d, i, ov, tbl[i].e_stb_v);
      chk("tbl_ack_cycle", tbl[i].d, i, oa, tbl[i].e_ack_c);
      chk("tbl_err_cycle", tbl[i].d, i, oe, tbl[i].e_err_c);
      chk("tbl_dat", tbl[i].d, i, rdat_o[tbl[i].d], tbl[i].e_dat);
    end

    // Asynchronous reset while dut0 is in its read-latency cycle.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 27'h41040; wdat[0] = 32'h0; sel[0] = 4'hF;
    drive_rdata(0, 1, 1'b0, 32'h5EED5EED);
    repeat (3) @(negedge clk);
    drive_rdata(0, 1, 1'b1, 32'h5EED5EED);
    #1 rst[0] = 1'b1;
    #1;
    chk("async_rst_a", 0, 3, {rdat_o[0], reg_wdata[0]}, 64'd0);
    chk("async_rst_b", 0, 3, {reg_we[0], reg_re[0], ack[0], err[0], reg_sel[0], reg_addr[0]}, 64'd0);
    @(negedge clk);
    rst[0] = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    dat_model[0] = 32'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", 0, c, {ack[0], err[0], reg_we[0], reg_re[0]}, 64'd0);
    end
    run_txn(0, 1'b0, 27'h41040, 32'h0, 4'hF, 32'h600DDA7A, 0, 1'b0, os, ov, oa, oe);
    chk("post_rst_read_ack", 0, 0, oa, 4);
    chk("post_rst_read_dat", 0, 0, rdat_o[0], 32'h600DDA7A);

    for (int i = 0; i < 140; i++) begin
      d     = (i < 80) ? 0 : 1;
      r     = int'($urandom_range(0, 7));
      w     = 1'($urandom_range(0, 1));
      a     = 27'($urandom);
      a[15:12] = 4'(r);
      v     = $urandom;
      drop  = (d == 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
      chain = ($urandom_range(0, 2) == 0) && (i != 79) && (i != 139);
      run_txn(d, w, a, $urandom, 4'($urandom), v, drop, chain, os, ov, oa, oe);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
